seq_detector_1011: RTL
======================

Name: seq_detector_1011

Overview:
- Serial bit-pattern detector sitting directly downstream of the tff_to_dff stage.
- Consumes the registered bit stream q, one bit per enabled clock, and detects the pattern 1011.
- Produces a one-cycle match pulse and a saturating match counter for the status/debug logic.
- MSB-first: the pattern is recognised when the last four accepted bits, oldest first, are 1,0,1,1.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (the trailing "1" of a match seeds the next); 0 = after a match, detection restarts from scratch.
- CNT_W, 8, width of match_count; the counter saturates at 2**CNT_W-1.

Ports:
- clk  input  1  rising-edge clock, shared with the tff_to_dff stage.
- rst  input  1  synchronous reset, active-high.
- din  input  1  serial data bit, driven by the q output of the upstream tff_to_dff.
- din_valid  input  1  din is consumed on a rising clk edge only when this is 1.
- cnt_clr  input  1  synchronous clear of match_count.
- match  output  1  registered one-cycle pulse: the pattern completed on the previous edge.
- match_count  output  CNT_W  number of matches since reset or clear, saturating.
- state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset: rst=1 sampled on a rising clk edge gives state=S_IDLE, match=0, match_count=0.
  - Reset takes priority over all other inputs.
  - Reset asserted mid-pattern discards the partial pattern.
- State encoding: S_IDLE=0, S_1=1, S_10=2, S_101=3, S_1011=4. Codes 5-7 are illegal and return to S_IDLE on the next edge.
- Transitions apply only on edges with din_valid=1:
  - S_IDLE: din=1 goes to S_1; din=0 stays in S_IDLE.
  - S_1: din=0 goes to S_10; din=1 stays in S_1.
  - S_10: din=1 goes to S_101; din=0 goes to S_IDLE.
  - S_101: din=1 goes to S_1011; din=0 goes to S_10 (overlap of "10").
  - S_1011 with OVERLAP=1: din=1 goes to S_1; din=0 goes to S_10.
  - S_1011 with OVERLAP=0: din=1 goes to S_1; din=0 goes to S_IDLE.
- din_valid=0: state holds and match is 0 on that edge. A held S_1011 does not re-pulse.
- match: registered, set to 1 on an edge where din_valid=1 and the next state is S_1011, else 0.
  - Latency: high for the cycle after the edge that consumed the final "1".
  - Consecutive matches with no gap are impossible, because each match needs at least 3 further bits.
- match_count update on each edge, in priority order:
  - rst gives 0.
  - cnt_clr gives 0. A clear wins over a simultaneous match, which is lost.
  - A match this edge with count < max gives count+1.
  - A match this edge with count at max holds max.
- Outputs are driven only from registers; there is no combinational path from din to any output.
- din is already registered upstream, so no input synchroniser is needed.

Decomposition:
- Package seq_det_pkg:
  - State localparams S_IDLE..S_1011.
  - STATE_W=3.
  - PATTERN=4'b1011, used as a documentation constant only.
- Sub-module sat_counter (params W; ports clk, rst, clr, inc, cnt).
  - Holds the saturating counter and is reusable elsewhere in the codebase.
- The FSM stays in seq_detector_1011.
- The bench instantiates tff_to_dff feeding seq_detector_1011 to prove the chained path.

Test Plan:
- Basic: rst for 2 cycles, then din=1,0,1,1 with valid=1 each cycle -> match=1 exactly in the cycle after the 4th bit; match_count=1; state_o=4.
- Overlap: din=1,0,1,1,0,1,1 with OVERLAP=1 -> 2 match pulses, 3 cycles apart, match_count=2. With OVERLAP=0 -> 1 pulse, count=1.
- Valid gaps: 1,0,(valid=0 for 3 cycles),1,1 -> one match; state holds through the gap. Holding valid=0 in S_1011 -> no second pulse.
- Reset mid-operation: feed 1,0,1, assert rst one cycle, feed 1 -> no match, state_o=1. A count of 5 before rst -> 0 after.
- Saturation and clear: CNT_W=2, 5 pulses -> match_count stays 3. cnt_clr coincident with a match -> count=0. The next match -> 1.
- Chained with tff_to_dff: drive d=1,0,1,1 one per clock -> its q reproduces the sequence one cycle later; match asserts one cycle after q presents the final 1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial 1011 pattern detector.
// State codes are exported on state_o for debug, so their values are fixed.
package seq_det_pkg;

    localparam int         STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1011;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_1011.sv
// Serial 1011 detector (MSB first) with registered match pulse and saturating match counter.
//
// state  | meaning
// S_IDLE | no useful prefix seen
// S_1    | last accepted bit is "1"
// S_10   | last accepted bits are "10"
// S_101  | last accepted bits are "101"
// S_1011 | full pattern just completed
module seq_detector_1011
    import seq_det_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [STATE_W-1:0] state_o
);

    state_t state_q;
    state_t state_d;
    logic   match_d;
    logic   match_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    // Illegal codes fall back to S_IDLE even on edges without din_valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (din_valid) state_d = din ? S_1    : S_IDLE;
            S_1:    if (din_valid) state_d = din ? S_1    : S_10;
            S_10:   if (din_valid) state_d = din ? S_101  : S_IDLE;
            S_101:  if (din_valid) state_d = din ? S_1011 : S_10;
            S_1011: begin
                if (din_valid) begin
                    if (din)               state_d = S_1;
                    else if (OVERLAP != 0) state_d = S_10;
                    else                   state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        match_d = din_valid && (state_d == S_1011);
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (match_d),
        .cnt (match_count)
    );

    assign match   = match_q;
    assign state_o = state_q;

endmodule
